// File: rtl/mux4_rr_scheduler.sv
// Round-robin arbiter for four requesters sharing one 4:1 data mux.
// Grants are held for at most MAX_HOLD cycles and hand over without an idle bubble.
module mux4_rr_scheduler #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] req_in,
  input  logic [3:0] d_in,
  output logic [3:0] gnt_out,
  output logic [1:0] sel_out,
  output logic       y_out,
  output logic       valid_out
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_d;
  logic [1:0]       sel_d;
  logic             y_d;
  logic             valid_d;

  logic             release_c;
  logic [1:0]       ptr_c;
  logic [1:0]       idx_c;
  logic [1:0]       win_c;
  logic             hit_c;

  // Current owner gives up the mux when it drops its request or its hold budget is spent
  always_comb begin
    release_c = 1'b0;
    if (state_q == GRANT) begin
      release_c = !req_in[sel_out] || (cnt_q == CNT_W'(MAX_HOLD));
    end
  end

  // A release updates the pointer in the same edge, so the search starts after the owner
  always_comb begin
    ptr_c = last_q;
    if (release_c) begin
      ptr_c = sel_out;
    end
  end

  // Search order ptr+1, ptr+2, ptr+3, ptr; the last slot allows re-granting the same index
  always_comb begin
    win_c = ptr_c;
    hit_c = 1'b0;
    idx_c = ptr_c;
    for (int i = 1; i <= 4; i++) begin
      idx_c = ptr_c + 2'(i);
      if (!hit_c && req_in[idx_c]) begin
        win_c = idx_c;
        hit_c = 1'b1;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_out;
    sel_d   = sel_out;
    y_d     = y_out;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (hit_c) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_c;
          sel_d   = win_c;
          cnt_d   = CNT_W'(1);
        end
      end

      GRANT: begin
        y_d     = d_in[sel_out];
        valid_d = 1'b1;
        if (release_c) begin
          last_d = sel_out;
          if (hit_c) begin
            gnt_d = 4'b0001 << win_c;
            sel_d = win_c;
            cnt_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State and output registers; last_q resets to 3 so requester 0 is searched first
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      gnt_out   <= 4'b0000;
      sel_out   <= 2'd0;
      y_out     <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt_out   <= gnt_d;
      sel_out   <= sel_d;
      y_out     <= y_d;
      valid_out <= valid_d;
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk_in) $onehot0(gnt_out));

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Scoreboard bench for mux4_rr_scheduler (MAX_HOLD = 4): directed steps push the
// expected post-edge outputs, a negedge monitor pops and compares them.
module tb_mux4_rr_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt_out;
  logic [1:0] sel_out;
  logic       y_out;
  logic       valid_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       valid;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  mux4_rr_scheduler #(.MAX_HOLD(4)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .req_in   (req),
    .d_in     (d),
    .gnt_out  (gnt_out),
    .sel_out  (sel_out),
    .y_out    (y_out),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per clock edge, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (gnt_out !== e.gnt) begin
        errors++;
        $display("FAIL %s gnt_out got %b expected %b", e.name, gnt_out, e.gnt);
      end
      checks++;
      if (sel_out !== e.sel) begin
        errors++;
        $display("FAIL %s sel_out got %0d expected %0d", e.name, sel_out, e.sel);
      end
      checks++;
      if (valid_out !== e.valid) begin
        errors++;
        $display("FAIL %s valid_out got %b expected %b", e.name, valid_out, e.valid);
      end
      checks++;
      if (y_out !== e.y) begin
        errors++;
        $display("FAIL %s y_out got %b expected %b", e.name, y_out, e.y);
      end
    end
  end

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dd,
                      input logic [3:0] eg, input logic [1:0] es, input logic ey,
                      input logic ev, input string nm);
    exp_t x;
    rst = r;
    req = rq;
    d   = dd;
    x.gnt = eg; x.sel = es; x.y = ey; x.valid = ev; x.name = nm;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] dpat;
    int edge_n;
    logic [1:0] g;
    logic [1:0] gp;
    logic       ey;
    rst = 1'b1; req = 4'b0000; d = 4'b0000;

    // Reset with all requests asserted
    step(1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0, "reset_a");
    step(1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0, "reset_b");

    // Single requester 2 held: grant, sample, then seamless re-grant after expiry
    step(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 0, 0, "single_first");
    for (int k = 0; k < 8; k++)
      step(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, "single_hold");

    // Reset mid-grant, then requests 1010
    step(1, 4'b1010, 4'b0000, 4'b0000, 2'd0, 0, 0, "rst_midgrant");
    step(0, 4'b1010, 4'b0010, 4'b0010, 2'd1, 0, 0, "post_rst_grant");
    step(0, 4'b1010, 4'b0010, 4'b0010, 2'd1, 1, 1, "post_rst_sample");

    // All four requesting: rotation 0,1,2,3,0, four cycles each
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, "rst_rr");
    dpat = 4'b1010;
    for (int gi = 0; gi < 5; gi++) begin
      for (int c = 0; c < 4; c++) begin
        edge_n = 1 + gi * 4 + c;
        g  = 2'(gi);
        gp = 2'(gi - 1);
        if (edge_n == 1)  ey = 1'b0;
        else if (c == 0)  ey = dpat[gp];
        else              ey = dpat[g];
        step(0, 4'b1111, dpat, 4'b0001 << g, g, ey, (edge_n == 1) ? 1'b0 : 1'b1, "rr_rotate");
      end
    end
    step(0, 4'b0000, dpat, 4'b0000, 2'd0, 0, 1, "rr_to_idle");
    step(0, 4'b0000, dpat, 4'b0000, 2'd0, 0, 0, "idle_hold");

    // Requester 0 drops in its second grant cycle, hand over to 1
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, "rst_drop");
    step(0, 4'b0011, 4'b0011, 4'b0001, 2'd0, 0, 0, "drop_grant0");
    step(0, 4'b0011, 4'b0011, 4'b0001, 2'd0, 1, 1, "drop_cycle2");
    step(0, 4'b0010, 4'b0011, 4'b0010, 2'd1, 1, 1, "drop_handover");
    step(0, 4'b0010, 4'b0011, 4'b0010, 2'd1, 1, 1, "grant1_hold");

    // Pointer at 2 after releasing requester 2: 3 beats 0
    step(0, 4'b0100, 4'b0011, 4'b0100, 2'd2, 1, 1, "to_req2");
    step(0, 4'b1001, 4'b1000, 4'b1000, 2'd3, 0, 1, "ptr2_pick3");
    step(0, 4'b1001, 4'b1000, 4'b1000, 2'd3, 1, 1, "grant3_sample");
    step(0, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1, 1, "release_idle");
    step(0, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1, 0, "idle_sel_hold");

    // Non-granted request changes leave the grant untouched
    step(0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1, 0, "other_grant0");
    step(0, 4'b0111, 4'b0001, 4'b0001, 2'd0, 1, 1, "other_noise_a");
    step(0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 1, 1, "other_noise_b");

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending got %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_scheduler.md
MUX4_RR_SCHEDULER -- requirements
Module: mux4_rr_scheduler

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive grant cycles per requester; legal range 1..15.
REQ-002 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 req_in  input  4  request lines; bit i = requester i wants the shared 4:1 mux path.
REQ-005 d_in  input  4  data bits; bit i = requester i's data, selected through the mux.
REQ-006 gnt_out  output  4  one-hot grant, registered; all zero when no grant.
REQ-007 sel_out  output  2  mux select, registered; equals index of the granted requester.
REQ-008 y_out  output  1  registered mux output, d_in[sel_out] sampled while granted.
REQ-009 valid_out  output  1  registered; high when y_out carries a sample taken during a grant cycle.

Function
REQ-010 Two states SHALL exist: IDLE (no grant) and GRANT (one requester owns the mux).
REQ-011 A 2-bit round-robin pointer last_q SHALL hold the index of the most recently released requester; search order is last_q+1, last_q+2, last_q+3, last_q (mod 4).
REQ-012 IDLE, req_in != 0 at edge N: SHALL enter GRANT at edge N with gnt_out one-hot and sel_out set to the first requesting index in search order; grant visible in cycle N+1 (1-cycle latency).
REQ-013 IDLE, req_in == 0: SHALL stay in IDLE; gnt_out = 0000, sel_out holds.
REQ-014 A hold counter SHALL load 1 on every new grant and increment each GRANT cycle; width clog2(MAX_HOLD)+1 bits, no wrap within legal range.
REQ-015 GRANT release condition: req_in[sel_out] == 0 sampled at edge, OR hold counter == MAX_HOLD.
REQ-016 On release: last_q <= sel_out; new search uses updated pointer in the same edge.
REQ-017 On release with any req_in bit set: SHALL grant the winner directly, no IDLE bubble; counter reloads to 1.
REQ-018 On release with req_in == 0: SHALL go to IDLE, gnt_out = 0000.
REQ-019 Hold expiry with only the current requester asserting: SHALL re-grant the same index (gnt_out unchanged), counter reloads to 1.
REQ-020 Each edge in GRANT: y_out <= d_in[sel_out], valid_out <= 1; in IDLE: valid_out <= 0, y_out holds.
REQ-021 gnt_out SHALL never have more than one bit set; sel_out SHALL only change when gnt_out changes or on reset.
REQ-022 Request changes on non-granted lines during GRANT SHALL not affect the current grant.

Reset
REQ-023 rst_in high at an edge SHALL force: state IDLE, gnt_out 0000, sel_out 00, y_out 0, valid_out 0, counter 0, last_q 3 (so index 0 has first priority).
REQ-024 Reset SHALL take priority over every other event, including mid-grant and simultaneous release; requests during reset are ignored.

Verification (MAX_HOLD = 4)
REQ-025 rst_in=1 for 2 cycles, req_in=1111 -> gnt_out 0000, sel_out 00, y_out 0, valid_out 0 throughout reset.
REQ-026 After reset, req_in=0100 held, d_in=0100 -> next cycle gnt_out 0100, sel_out 10; following cycle y_out 1, valid_out 1; after 4 grant cycles re-grant to 2 with no gap, gnt_out stays 0100.
REQ-027 After reset, req_in=1111 held -> grants 0001, 0010, 0100, 1000, 0001 each for exactly 4 cycles, back-to-back, valid_out continuously 1 after first grant.
REQ-028 req_in=0011, requester 0 granted; req_in[0] drops in 2nd grant cycle -> next cycle gnt_out 0010, sel_out 01.
REQ-029 last_q=2 (after releasing requester 2), req_in=1001 -> gnt_out 1000, sel_out 11 (3 beats 0).
REQ-030 rst_in pulsed for 1 cycle while gnt_out=0100, then req_in=1010 -> gnt_out 0000 during reset, then 0010 one cycle after rst_in falls.
